// File: rtl/moddiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | moddiv_pkg: shared types and constants for the modular add/sub sequencer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package moddiv_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_NWORDS = 16;
  localparam int CNT_W      = $clog2(DEF_NWORDS);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_LOAD_P = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_UNLOAD = 3'd6
  } state_t;

  function automatic logic is_load(input state_t s);
    return (s == ST_LOAD_A) || (s == ST_LOAD_B) || (s == ST_LOAD_P);
  endfunction

endpackage
`default_nettype wire

// File: rtl/moddiv_word_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | moddiv_word_cnt: modulo-NWORDS word counter with enable, clear and TC      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module moddiv_word_cnt
  import moddiv_pkg::*;
#(
  parameter int NWORDS = DEF_NWORDS,
  parameter int CW     = $clog2(NWORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(NWORDS - 1));

  // Clear has priority so a new phase always starts from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule
`default_nettype wire

// File: rtl/madd_msub_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | madd_msub_sequencer: command/operand front end for the modular add/sub unit|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module madd_msub_sequencer
  import moddiv_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int NWORDS  = DEF_NWORDS,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_keep_p,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [WORD_W-1:0] datain,
  output logic              loada,
  output logic              loadb,
  output logic              loadp,
  output logic              madd_en,
  output logic              msub_en,
  output logic              outs0,
  output logic              outs1,
  input  logic [WORD_W-1:0] regs0out,
  input  logic [WORD_W-1:0] regs1out,
  input  logic              result_rdy,
  input  logic              result_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CW   = $clog2(NWORDS);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          r_state;
  state_t          w_next;
  logic            r_op;
  logic            r_keep_p;
  logic            r_sel;
  logic            r_err;
  logic [WD_W-1:0] r_wd;

  logic [CW-1:0]   w_cnt;
  logic            w_tc;
  logic            w_cmd_acc;
  logic            w_xfer_in;
  logic            w_xfer_out;
  logic            w_wd_exp;
  logic            w_res_acc;

  assign w_cmd_acc  = (r_state == ST_IDLE) & cmd_valid;
  assign w_xfer_in  = is_load(r_state) & in_valid;
  assign w_xfer_out = (r_state == ST_UNLOAD) & out_ready;
  assign w_res_acc  = (r_state == ST_WAIT) & result_rdy;
  assign w_wd_exp   = (r_wd == WD_W'(TIMEOUT - 1));

  // One counter serves both the load phases and the unload phase.
  moddiv_word_cnt #(
    .NWORDS (NWORDS),
    .CW     (CW)
  ) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_xfer_in | w_xfer_out),
    .i_clr (w_cmd_acc | w_res_acc),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_next = ST_LOAD_A;
      ST_LOAD_A: if (w_xfer_in && w_tc) w_next = ST_LOAD_B;
      ST_LOAD_B: if (w_xfer_in && w_tc) w_next = r_keep_p ? ST_START : ST_LOAD_P;
      ST_LOAD_P: if (w_xfer_in && w_tc) w_next = ST_START;
      ST_START:  w_next = ST_WAIT;
      // A result arriving on the expiry cycle still gets unloaded.
      ST_WAIT: begin
        if (result_rdy) begin
          w_next = ST_UNLOAD;
        end else if (w_wd_exp) begin
          w_next = ST_IDLE;
        end
      end
      ST_UNLOAD: if (w_xfer_out && w_tc) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    datain    = '0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadp     = 1'b0;
    madd_en   = 1'b0;
    msub_en   = 1'b0;
    outs0     = 1'b0;
    outs1     = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD_A: begin
        in_ready = 1'b1;
        datain   = in_data;
        loada    = in_valid;
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        datain   = in_data;
        loadb    = in_valid;
      end
      ST_LOAD_P: begin
        in_ready = 1'b1;
        datain   = in_data;
        loadp    = in_valid;
      end
      ST_START: begin
        madd_en = (r_op == OP_ADD);
        msub_en = (r_op == OP_SUB);
      end
      // The unit only advances on outsX, so out_data holds while stalled.
      ST_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = r_sel ? regs1out : regs0out;
        outs0     = ~r_sel & out_ready;
        outs1     = r_sel & out_ready;
        out_last  = (w_cnt == CW'(NWORDS - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_keep_p <= 1'b0;
      r_sel    <= 1'b0;
      r_wd     <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_cmd_acc) begin
        r_op     <= cmd_op;
        r_keep_p <= cmd_keep_p;
        r_err    <= 1'b0;
      end
      if (r_state == ST_START) begin
        r_wd <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_res_acc) begin
        r_sel <= result_flag;
      end
      if ((r_state == ST_WAIT) && !result_rdy && w_wd_exp) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_madd_msub_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_madd_msub_sequencer: directed self-checking bench for the sequencer     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_madd_msub_sequencer;

  localparam int WW = 16;
  localparam int NW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_op = 1'b0, cmd_keep_p = 1'b0;
  logic          cmd_ready;
  logic          in_valid = 1'b0, in_ready;
  logic [WW-1:0] in_data = '0, datain;
  logic          loada, loadb, loadp, madd_en, msub_en, outs0, outs1;
  logic [WW-1:0] regs0out, regs1out;
  logic          result_rdy = 1'b0, result_flag = 1'b0;
  logic          out_valid, out_ready = 1'b0, out_last, busy, err_timeout;
  logic [WW-1:0] out_data;

  int total = 0;
  int bad   = 0;

  madd_msub_sequencer #(.WORD_W(WW), .NWORDS(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_keep_p(cmd_keep_p),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .datain(datain),
    .loada(loada), .loadb(loadb), .loadp(loadp), .madd_en(madd_en), .msub_en(msub_en),
    .outs0(outs0), .outs1(outs1), .regs0out(regs0out), .regs1out(regs1out),
    .result_rdy(result_rdy), .result_flag(result_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Result-register model of the unit: index restarts when a result is offered.
  logic [WW-1:0] r_idx = '0;
  always @(posedge clk) begin
    if (result_rdy) r_idx <= '0;
    else if (outs0 || outs1) r_idx <= r_idx + 1'b1;
  end
  assign regs0out = 16'hB000 + r_idx;
  assign regs1out = 16'hA000 + r_idx;

  // Event monitor.
  int cyc = 0;
  int n_la = 0, n_lb = 0, n_lp = 0, n_madd = 0, n_msub = 0, n_o0 = 0, n_o1 = 0, n_ov = 0;
  int sum_a = 0, sum_b = 0, sum_p = 0;
  int t_lb = 0, t_lp = 0, t_madd = 0, t_msub = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (loada) begin n_la <= n_la + 1; sum_a <= sum_a + int'(datain); end
    if (loadb) begin n_lb <= n_lb + 1; sum_b <= sum_b + int'(datain); t_lb <= cyc; end
    if (loadp) begin n_lp <= n_lp + 1; sum_p <= sum_p + int'(datain); t_lp <= cyc; end
    if (madd_en) begin n_madd <= n_madd + 1; t_madd <= cyc; end
    if (msub_en) begin n_msub <= n_msub + 1; t_msub <= cyc; end
    if (outs0) n_o0 <= n_o0 + 1;
    if (outs1) n_o1 <= n_o1 + 1;
    if (out_valid) n_ov <= n_ov + 1;
  end

  int b_la, b_lb, b_lp, b_madd, b_msub, b_o0, b_o1, b_ov, b_sa, b_sb, b_sp;

  task automatic snap();
    b_la = n_la; b_lb = n_lb; b_lp = n_lp; b_madd = n_madd; b_msub = n_msub;
    b_o0 = n_o0; b_o1 = n_o1; b_ov = n_ov; b_sa = sum_a; b_sb = sum_b; b_sp = sum_p;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic keep);
    cmd_valid = 1'b1; cmd_op = op; cmd_keep_p = keep;
    #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_words(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = WW'(first + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic unload_fast(input logic flag);
    result_rdy = 1'b1; result_flag = flag;
    tick();
    result_rdy = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < NW; i++) begin
      #1;
      chk("fast_valid", 32'(out_valid), 32'd1);
      chk("fast_data", 32'(out_data), 32'((flag ? 16'hA000 : 16'hB000) + i));
      chk("fast_last", 32'(out_last), 32'(i == NW - 1));
      chk("fast_outs0", 32'(outs0), 32'(!flag));
      chk("fast_outs1", 32'(outs1), 32'(flag));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("fast_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    // Reset state.
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_start", 32'({madd_en, msub_en, loada, loadb, loadp}), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // Add, keep_p=0, continuous operand stream.
    snap();
    send_cmd(1'b0, 1'b0);
    load_words(16, 1);
    load_words(16, 16);
    load_words(16, 32);
    #1;
    chk("add_madd_en", 32'(madd_en), 32'd1);
    chk("add_msub_en", 32'(msub_en), 32'd0);
    tick();
    chk("add_wait_busy", 32'(busy), 32'd1);
    chk("add_n_la", 32'(n_la - b_la), 32'd16);
    chk("add_n_lb", 32'(n_lb - b_lb), 32'd16);
    chk("add_n_lp", 32'(n_lp - b_lp), 32'd16);
    chk("add_sum_a", 32'(sum_a - b_sa), 32'd136);
    chk("add_sum_b", 32'(sum_b - b_sb), 32'd376);
    chk("add_sum_p", 32'(sum_p - b_sp), 32'd632);
    chk("add_madd_cnt", 32'(n_madd - b_madd), 32'd1);
    chk("add_msub_cnt", 32'(n_msub - b_msub), 32'd0);
    chk("add_start_lat", 32'(t_madd - t_lp), 32'd1);
    unload_fast(1'b0);

    // Sub, keep_p=1, 3-cycle gap mid-A, command held during LOAD_B.
    snap();
    send_cmd(1'b1, 1'b1);
    load_words(8, 100);
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("gap_loada", 32'(loada), 32'd0);
      chk("gap_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    load_words(8, 108);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_keep_p = 1'b0;
    in_valid = 1'b1; in_data = 16'd200;
    #1;
    chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("busy_loadb", 32'(loadb), 32'd1);
    load_words(16, 200);
    cmd_valid = 1'b0;
    #1;
    chk("sub_msub_en", 32'(msub_en), 32'd1);
    chk("sub_madd_en", 32'(madd_en), 32'd0);
    tick();
    chk("sub_n_la", 32'(n_la - b_la), 32'd16);
    chk("sub_sum_a", 32'(sum_a - b_sa), 32'd1720);
    chk("sub_n_lb", 32'(n_lb - b_lb), 32'd16);
    chk("sub_n_lp", 32'(n_lp - b_lp), 32'd0);
    chk("sub_start_lat", 32'(t_msub - t_lb), 32'd1);
    chk("sub_madd_cnt", 32'(n_madd - b_madd), 32'd0);
    tick(); tick();
    result_rdy = 1'b1; result_flag = 1'b1;
    tick();
    result_rdy = 1'b0;
    k = 0;
    for (int c = 0; c < 64 && k < NW; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(16'hA000 + k));
      chk("bp_outs1", 32'(outs1), 32'(out_ready));
      chk("bp_outs0", 32'(outs0), 32'd0);
      chk("bp_last", 32'(out_last), 32'(k == NW - 1));
      if (out_ready) k++;
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("bp_words", 32'(k), 32'(NW));
    chk("bp_busy_fall", 32'(busy), 32'd0);
    chk("bp_outs1_cnt", 32'(n_o1 - b_o1), 32'(NW));
    chk("bp_outs0_cnt", 32'(n_o0 - b_o0), 32'd0);

    // Timeout: unit never answers.
    snap();
    send_cmd(1'b0, 1'b1);
    load_words(32, 300);
    tick();
    repeat (7) tick();
    chk("to_still_wait", 32'(busy), 32'd1);
    chk("to_err_early", 32'(err_timeout), 32'd0);
    tick();
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_no_output", 32'(n_ov - b_ov), 32'd0);
    send_cmd(1'b0, 1'b0);
    chk("to_err_clear", 32'(err_timeout), 32'd0);

    // Reset mid LOAD_B at word 5.
    load_words(16, 400);
    load_words(5, 500);
    in_valid = 1'b1; in_data = 16'd505;
    #1;
    chk("pre_rst_loadb", 32'(loadb), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_strobes", 32'({loada, loadb, loadp, in_ready, out_valid}), 32'd0);
    chk("mid_rst_datain", 32'(datain), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Fresh add after reset.
    snap();
    send_cmd(1'b0, 1'b0);
    load_words(48, 600);
    #1;
    chk("re_madd_en", 32'(madd_en), 32'd1);
    tick();
    chk("re_n_la", 32'(n_la - b_la), 32'd16);
    chk("re_n_lb", 32'(n_lb - b_lb), 32'd16);
    chk("re_n_lp", 32'(n_lp - b_lp), 32'd16);
    chk("re_start_lat", 32'(t_madd - t_lp), 32'd1);
    unload_fast(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/madd_msub_sequencer.md
Name: madd_msub_sequencer

Overview:
- Front-end sequencer directly upstream of the modular add/subtract datapath-plus-control unit.
- Accepts a command (add/sub, reuse-modulus flag) from a host over a valid/ready handshake, then streams 16-bit operand words for A, B and P into the unit.
- Pulses the add or subtract start, waits for completion, then unloads the result word-by-word from whichever result register the unit flags, with output backpressure.

Parameters:
- WORD_W, 16, operand word width; equals the unit's datain width.
- NWORDS, 16, words per operand; the operand is NWORDS*WORD_W bits.
- TIMEOUT, 1024, maximum cycles in WAIT before an error is raised.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = modular add, 1 = modular subtract.
- cmd_keep_p  in  1  1 = skip P load and reuse the modulus already held.
- in_valid  in  1  operand word valid.
- in_ready  out  1  high in LOAD_A, LOAD_B and LOAD_P.
- in_data  in  WORD_W  operand word, least-significant word first.
- datain  out  WORD_W  to unit; equals in_data while loading, else 0.
- loada, loadb, loadp  out  1  to unit; loadX = (state==LOAD_X) & in_valid.
- madd_en, msub_en  out  1  to unit; one-cycle start pulse.
- outs0, outs1  out  1  to unit; advances the selected result register by one word.
- regs0out, regs1out  in  WORD_W  from unit; current result word.
- result_rdy, result_flag  in  1  from unit; flag=0 selects regs0out, flag=1 selects regs1out.
- out_valid  out  1  result word valid.
- out_ready  in  1  host accepts the result word.
- out_data  out  WORD_W  result word, LSW first.
- out_last  out  1  high with word NWORDS-1.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky; cleared by the next accepted command.

Behaviour:
- Reset values: state=IDLE, word count=0, op=0, keep_p=0, sel=0, watchdog=0. All outputs 0 except cmd_ready=1.
- States: IDLE, LOAD_A, LOAD_B, LOAD_P, START, WAIT, UNLOAD.
- IDLE: on cmd_valid, latch op and keep_p, clear err_timeout, go to LOAD_A with count=0.
- LOAD_X: each cycle with in_valid=1, one word is transferred and count increments.
  - A gap cycle (in_valid=0) drives no load strobe and holds the state.
  - After word NWORDS-1, wrap count to 0 and advance: A -> B -> P -> START.
  - If keep_p=1, B advances directly to START.
- START: exactly one cycle; madd_en=1 if op=0, msub_en=1 if op=1, never both. Next state WAIT, watchdog=0.
- WAIT: watchdog increments each cycle.
  - On result_rdy=1: latch sel=result_flag and go to UNLOAD with count=0.
  - If the watchdog reaches TIMEOUT-1 without result_rdy: set err_timeout and go to IDLE, with no output words.
  - If result_rdy and timeout coincide, result_rdy wins.
- UNLOAD:
  - out_valid=1; out_data = sel ? regs1out : regs0out.
  - outs0 = ~sel & out_ready; outs1 = sel & out_ready (combinational).
  - On each accepted word, count increments. out_last = (count==NWORDS-1).
  - After the last word is accepted, go to IDLE.
  - While out_ready=0: outs0 and outs1 stay 0 and out_data is held stable.
- Latency:
  - Command acceptance to first load strobe: 1 cycle.
  - Last load to start pulse: 1 cycle.
  - result_rdy to first out_valid: 1 cycle.
- A command presented while busy is not accepted; cmd_ready=0 and no state is disturbed.
- The count is log2(NWORDS) bits and wraps NWORDS-1 -> 0 only on the transfer of the last word.
- Reset asserted mid-operation: immediate return to IDLE with reset values. Partially loaded unit registers are not cleared; the next command reloads them. A keep_p=1 command after such a reset reuses an undefined modulus; the host is responsible for avoiding this.

Decomposition:
- Shared package moddiv_pkg:
  - state enum (7 codes);
  - op codes OP_ADD=0, OP_SUB=1;
  - WORD_W and NWORDS defaults;
  - CNT_W = clog2(NWORDS).
- One sub-module, moddiv_word_cnt: a modulo-NWORDS counter with enable and clear, and a terminal-count output. It is instantiated once and shared by the load and unload phases.
- The watchdog stays inline.

Test Plan:
- Add, keep_p=0, words A=1..16, B=16..31, P=32..47 with in_valid continuous -> 48 cycles of loads (16 loada, 16 loadb, 16 loadp); a single madd_en pulse 1 cycle after the last loadp; msub_en stays 0.
- Sub, keep_p=1 -> loadp never asserted; msub_en pulses 1 cycle after the 16th loadb.
- Model asserts result_rdy with result_flag=1 and regs1out sequence 0xA000..0xA00F; out_ready toggles 1,0,1,0 -> 16 words 0xA000..0xA00F in order. outs1 fires only on accepted cycles and outs0 is never asserted. out_last is high only with 0xA00F; busy falls the cycle after.
- Model never asserts result_rdy, TIMEOUT=8 -> err_timeout=1 after 8 WAIT cycles, state IDLE, out_valid never high. The next accepted command clears err_timeout.
- cmd_valid held high during LOAD_B, and in_valid deasserted for 3 cycles mid-A -> no second command accepted; no loada during the gap; the word count resumes correctly.
- rst pulsed while in LOAD_B at word 5 -> all outputs 0 and cmd_ready=1 immediately. A fresh add command completes the normal 48-load sequence.
